clock_mode_controller: RTL
==========================

// Module: clock_mode_controller
// PURPOSE
//  Sequencer for the digital clock's chained counter instances (seconds, minutes, hours, alarm hours, alarm minutes).
//  Generates the 1 Hz timebase, cascades the enable chain from the counters' terminal-count flags, and runs
//  the mode FSM so that debounced user buttons step the adjust fields. Sits between the button debouncers and
//  the counter bank; it holds no time values itself.
// PARAMETERS
//  TICK_DIV   100_000_000  clk cycles per 1 s tick (>=2)
//  BLINK_DIV  50_000_000   clk cycles per blink half-period in SET states (>=2)
//  DIV_W      27           width of both prescalers; must hold max(TICK_DIV,BLINK_DIV)-1
// PORTS
//  clk           in   1  system clock, all state on rising edge
//  reset         in   1  asynchronous, active-high; clears all state
//  btn_mode      in   1  single-cycle pulse, advance mode
//  btn_up        in   1  single-cycle pulse, increment selected field
//  sec_tc        in   1  seconds counter at n-1
//  min_tc        in   1  minutes counter at n-1
//  tick          out  1  registered 1-cycle pulse every TICK_DIV cycles while timebase runs
//  sec_en        out  1  enable to seconds counter
//  min_en        out  1  enable to minutes counter
//  hr_en         out  1  enable to hours counter
//  al_min_en     out  1  enable to alarm-minutes counter
//  al_hr_en      out  1  enable to alarm-hours counter
//  sec_clr       out  1  registered 1-cycle pulse, synchronous clear request to seconds counter
//  mode          out  3  current state encoding (see BEHAVIOUR)
//  blink         out  1  display blink for selected field
// BEHAVIOUR
//  Reset values: state RUN, both prescalers 0, tick=0, sec_clr=0, blink=1; all *_en are 0 in RUN with tick=0.
//  States/encoding: RUN=0, SET_H=1, SET_M=2, SET_AH=3, SET_AM=4; mode = state; codes 5-7 are illegal -> RUN next cycle.
//  Transitions on btn_mode only: RUN->SET_H->SET_M->SET_AH->SET_AM->RUN.
//  Timebase: prescaler counts 0..TICK_DIV-1 in RUN, SET_AH, SET_AM; at TICK_DIV-1 it wraps to 0 and tick=1 next cycle.
//   In SET_H/SET_M the prescaler is held at 0 and tick=0 (time frozen while adjusting).
//  Enables are combinational from registered state/tick plus inputs (zero latency):
//   sec_en    = tick
//   min_en    = tick & sec_tc                          | (state==SET_M  & btn_up)
//   hr_en     = tick & sec_tc & min_tc                 | (state==SET_H  & btn_up)
//   al_hr_en  = state==SET_AH & btn_up
//   al_min_en = state==SET_AM & btn_up
//  Adjust does not carry: btn_up in SET_M at minute 59 wraps minutes only; hr_en stays 0.
//  btn_up in RUN is ignored. btn_mode and btn_up in the same cycle: mode advances, btn_up ignored (no *_en from it).
//  sec_clr: 1 for exactly one cycle after the SET_M->SET_AH transition; the prescaler restarts at 0 on the same edge.
//  Blink: in RUN blink=1 and the blink prescaler is held at 0. In any SET state blink toggles every BLINK_DIV cycles.
//   On every state change the prescaler clears to 0 and blink goes to 1.
//  Reset mid-operation, including mid-tick or during sec_clr: all state returns to the reset values immediately.
//   Pulses are truncated and no enable is issued afterwards.
// TESTING (TICK_DIV=4, BLINK_DIV=3)
//  reset released, RUN, no buttons -> tick and sec_en high 1 cycle in every 4; min_en, hr_en stay 0 with sec_tc=0.
//  RUN, sec_tc=1, min_tc=1 held -> min_en and hr_en pulse coincident with each tick.
//  2x btn_mode then btn_up -> mode=2, min_en=1 for that cycle only; tick stays 0; hr_en=0 with min_tc=1.
//  From SET_M, btn_mode -> mode=3, sec_clr=1 next cycle only, first tick 4 cycles after the transition.
//  btn_mode and btn_up same cycle in SET_AH -> mode=4, al_hr_en=0; btn_mode again -> mode=0, blink=1.
//  reset pulsed mid-count in SET_AM -> mode=0, tick=0, blink=1, all *_en=0 immediately.

Source files
------------

// File: rtl/clock_mode_controller.sv
// Mode sequencer for the digital clock: 1 Hz timebase, counter enable
// chain, adjust-mode FSM and display blink generation.
module clock_mode_controller #(
  parameter int TICK_DIV  = 100_000_000,
  parameter int BLINK_DIV = 50_000_000,
  parameter int DIV_W     = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       sec_tc,
  input  logic       min_tc,
  output logic       tick,
  output logic       sec_en,
  output logic       min_en,
  output logic       hr_en,
  output logic       al_min_en,
  output logic       al_hr_en,
  output logic       sec_clr,
  output logic [2:0] mode,
  output logic       blink
);

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    SET_H  = 3'd1,
    SET_M  = 3'd2,
    SET_AH = 3'd3,
    SET_AM = 3'd4
  } state_e;

  localparam logic [DIV_W-1:0] TICK_MAX  = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] BLINK_MAX = DIV_W'(BLINK_DIV - 1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] bdiv_q, bdiv_d;
  logic             tick_q, tick_d;
  logic             clr_q, clr_d;
  logic             blink_q, blink_d;
  logic             up;
  logic             run_tb;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      div_q   <= '0;
      bdiv_q  <= '0;
      tick_q  <= 1'b0;
      clr_q   <= 1'b0;
      blink_q <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bdiv_q  <= bdiv_d;
      tick_q  <= tick_d;
      clr_q   <= clr_d;
      blink_q <= blink_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (btn_mode) state_d = SET_H;
      SET_H:   if (btn_mode) state_d = SET_M;
      SET_M:   if (btn_mode) state_d = SET_AH;
      SET_AH:  if (btn_mode) state_d = SET_AM;
      SET_AM:  if (btn_mode) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Time is frozen while hours/minutes are being adjusted; leaving
  // SET_M restarts the second from zero.
  always_comb begin
    div_d  = '0;
    tick_d = 1'b0;
    run_tb = (state_d == RUN) || (state_d == SET_AH) ||
             (state_d == SET_AM);
    if (run_tb && (state_q != SET_M)) begin
      if (div_q == TICK_MAX) begin
        tick_d = 1'b1;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  assign clr_d = (state_q == SET_M) && btn_mode;

  always_comb begin
    bdiv_d  = bdiv_q;
    blink_d = blink_q;
    if ((state_d != state_q) || (state_d == RUN)) begin
      bdiv_d  = '0;
      blink_d = 1'b1;
    end else if (bdiv_q == BLINK_MAX) begin
      bdiv_d  = '0;
      blink_d = ~blink_q;
    end else begin
      bdiv_d = bdiv_q + DIV_W'(1);
    end
  end

  // A mode press in the same cycle wins over an adjust press.
  assign up = btn_up & ~btn_mode;

  assign tick      = tick_q;
  assign sec_en    = tick_q;
  assign min_en    = (tick_q & sec_tc) | ((state_q == SET_M) & up);
  assign hr_en     = (tick_q & sec_tc & min_tc) |
                     ((state_q == SET_H) & up);
  assign al_hr_en  = (state_q == SET_AH) & up;
  assign al_min_en = (state_q == SET_AM) & up;
  assign sec_clr   = clr_q;
  assign mode      = state_q;
  assign blink     = blink_q;

endmodule
